// File: rtl/hazard_pkg.sv
// Shared constants for the ID-stage hazard / forwarding unit.
//   - SEL_* : operand-mux select encodings (0 = register file, k = stage k-1)
//   - sel_width() : width of one operand-mux select for a given stage count
//   - DEF_* : default geometry used by the top level
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_LOAD_LAT   = 1;

  localparam int SEL_RF  = 0;
  localparam int SEL_EX  = 1;
  localparam int SEL_MEM = 2;
  localparam int SEL_WB  = 3;

  // One select must encode "register file" plus every forwarding stage.
  // Never return zero, so a degenerate single-stage build still has a bit.
  function automatic int sel_width(input int num_fwd);
    int w;
    w = $clog2(num_fwd + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_fwd_scoreboard_fwd_select.sv
// Forwarding source selection for a single source operand.
//   src_addr_i  : register address read by this operand
//   src_used_i  : operand is actually read
//   fwd_rd_i    : destination register per forwarding stage (stage 0 = EX)
//   fwd_rf_le_i : write enable per forwarding stage
//   sel_o       : 0 = register file, k = forward from stage k-1
// Purely combinational; the youngest matching stage wins.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_FWD    = 3,
  parameter int SEL_W      = sel_width(NUM_FWD)
) (
  input  logic [REG_ADDR_W-1:0]         src_addr_i,
  input  logic                          src_used_i,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd_i,
  input  logic [NUM_FWD-1:0]            fwd_rf_le_i,
  output logic [SEL_W-1:0]              sel_o
);

  always_comb begin
    // NOTE: a default assignment before any conditional keeps this block
    // purely combinational; without it an unmatched path would infer a latch.
    sel_o = SEL_W'(SEL_RF);
    // Walk from oldest to youngest so the youngest match is written last.
    // src_addr_i != 0 already excludes stages whose destination is r0.
    if (src_used_i && (src_addr_i != '0)) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_rf_le_i[k] && (fwd_rd_i[k*REG_ADDR_W +: REG_ADDR_W] == src_addr_i)) begin
          sel_o = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// ID-stage hazard detection, operand forwarding and load-latency scoreboard.
//   clk, rst_n            : clock, synchronous active-low reset
//   id_valid              : valid instruction in ID
//   id_src, id_src_used   : packed source addresses and per-source read flags
//   id_rd, id_rf_le       : destination and register-file write enable
//   id_is_load            : ID instruction is a load
//   flush                 : kill the ID instruction
//   fwd_rd, fwd_rf_le     : destination / write enable per forwarding stage
//   stall_clr             : clear the stall-cycle counter
//   nop, id_le            : bubble into EX / IF-ID load enable
//   src_sel               : per-source operand mux select
//   sb_busy               : some load result is still in flight
//   stall_cycles          : saturating stall-cycle counter
module hazard_fwd_scoreboard
  import hazard_pkg::*;
#(
  parameter  int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter  int NUM_SRC     = 2,
  parameter  int NUM_FWD     = 3,
  parameter  int LOAD_LAT    = DEF_LOAD_LAT,
  parameter  int STALL_CNT_W = 16,
  localparam int SEL_W       = sel_width(NUM_FWD)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_rf_le,
  input  logic                          id_is_load,
  input  logic                          flush,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]            fwd_rf_le,
  input  logic                          stall_clr,
  output logic                          nop,
  output logic                          id_le,
  output logic [NUM_SRC*SEL_W-1:0]      src_sel,
  output logic                          sb_busy,
  output logic [STALL_CNT_W-1:0]        stall_cycles
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int CNT_W    = $clog2(LOAD_LAT + 1);

  logic [CNT_W-1:0]         cnt_q [NUM_REGS];
  logic [CNT_W-1:0]         cnt_d [NUM_REGS];
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]       haz;
  logic [NUM_SRC*SEL_W-1:0] sel_raw;
  logic                     stall, issue, load_alloc, busy_any;

  // A source is hazardous while its register still has cycles left before
  // the load result can be forwarded. r0 is hard-wired and never waits.
  always_comb begin
    haz = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      haz[s] = id_valid && id_src_used[s]
               && (id_src[s*REG_ADDR_W +: REG_ADDR_W] != '0)
               && (cnt_q[id_src[s*REG_ADDR_W +: REG_ADDR_W]] != '0);
    end
  end

  // A flushed instruction is discarded anyway, so it never holds IF/ID.
  assign stall      = (|haz) & ~flush;
  assign issue      = id_valid & ~stall & ~flush;
  assign load_alloc = issue & id_is_load & id_rf_le & (id_rd != '0);

  // All pending entries age by one; a newly issued load re-arms its entry,
  // which also supersedes any older load to the same register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : cnt_q[r];
    end
    if (load_alloc) begin
      cnt_d[id_rd] = CNT_W'(LOAD_LAT);
    end
  end

  always_comb begin
    busy_any = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_any = busy_any | (cnt_q[r] != '0);
    end
  end

  // Clear wins over counting; counting stops at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the counter array is reset explicitly because stale entries
      // would produce phantom stalls after reset; a plain data RAM would not
      // need this.
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge state, independent of statement order.
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_select #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_FWD    (NUM_FWD),
      .SEL_W      (SEL_W)
    ) u_fwd_select (
      .src_addr_i  (id_src[s*REG_ADDR_W +: REG_ADDR_W]),
      .src_used_i  (id_src_used[s]),
      .fwd_rd_i    (fwd_rd),
      .fwd_rf_le_i (fwd_rf_le),
      .sel_o       (sel_raw[s*SEL_W +: SEL_W])
    );
  end

  // Outputs are held at their idle values while reset is asserted.
  assign nop          = rst_n & (stall | flush);
  assign id_le        = ~rst_n | ~stall;
  assign src_sel      = rst_n ? sel_raw : '0;
  assign sb_busy      = rst_n & busy_any;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: doc/hazard_fwd_scoreboard.md
Name: hazard_fwd_scoreboard

Overview:
- Parametrised successor to the single-cycle hazard/forwarding unit, serving the PA-RISC pipeline's ID stage.
- Generalises to N source operands and M forwarding stages, and selects forwarding sources by youngest-stage priority.
- Adds a per-register scoreboard that tracks multi-cycle load latency, so stalls last exactly as long as the data is unavailable.
- Adds flush handling and a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5: register-address width; the scoreboard has 2**REG_ADDR_W entries, and r0 is never tracked.
- NUM_SRC, 2: number of source operands checked per ID instruction.
- NUM_FWD, 3: number of forwarding stages; index 0 = EX (youngest), 1 = MEM, 2 = WB.
- LOAD_LAT, 1: cycles after a load leaves ID during which its result cannot be forwarded. Must be >= 1.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  a valid instruction is in ID
- id_src  in  NUM_SRC*REG_ADDR_W  source register addresses; slot s is at [s*REG_ADDR_W +: REG_ADDR_W]
- id_src_used  in  NUM_SRC  bit s set means source s is actually read
- id_rd  in  REG_ADDR_W  destination register of the ID instruction
- id_rf_le  in  1  the ID instruction writes the register file
- id_is_load  in  1  the ID instruction is a load
- flush  in  1  kill the instruction in ID (taken branch or nullify)
- fwd_rd  in  NUM_FWD*REG_ADDR_W  destination register per forwarding stage
- fwd_rf_le  in  NUM_FWD  write enable per forwarding stage
- stall_clr  in  1  synchronous clear of stall_cycles
- nop  out  1  inject a bubble into EX
- id_le  out  1  load enable for the IF/ID registers
- src_sel  out  NUM_SRC*SEL_W  operand mux select; SEL_W = $clog2(NUM_FWD+1); 0 = register file, k = forwarding stage k-1
- sb_busy  out  1  at least one scoreboard counter is nonzero
- stall_cycles  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard state:
  - cnt[r] per register, width $clog2(LOAD_LAT+1).
  - Reset sets every cnt to 0 and stall_cycles to 0.
  - While rst_n is low, outputs are forced to nop=0, id_le=1, src_sel=0, sb_busy=0.
- Per-source hazard:
  - haz[s] = id_valid & id_src_used[s] & (addr_s != 0) & (cnt[addr_s] != 0).
  - stall = |haz & ~flush.
- Issue condition: id_valid & ~stall & ~flush.
- Scoreboard update each cycle:
  - Every nonzero cnt decrements by 1.
  - If issue & id_is_load & id_rf_le & (id_rd != 0), then cnt[id_rd] <= LOAD_LAT.
  - A same-cycle issue overrides the decrement on the same entry, including when an older load to that register is still pending.
- Forwarding (combinational, per source s):
  - If addr_s == 0 or the source is unused, src_sel = 0.
  - Otherwise select the lowest stage index k with fwd_rf_le[k] & fwd_rd[k] == addr_s & fwd_rd[k] != 0, and output k+1.
  - If no stage matches, output 0.
  - Youngest-stage priority resolves multiple matches.
  - src_sel is still computed during a stall; downstream ignores it because nop=1.
- Control outputs:
  - stall: nop=1, id_le=0.
  - flush: nop=1, id_le=1. Flush dominates stall; the instruction is not issued and the scoreboard only decrements.
  - Otherwise: nop=0, id_le=1.
- stall_cycles:
  - Increments by 1 on each stall cycle and saturates at all-ones.
  - stall_clr has priority over the increment.
- Latency with LOAD_LAT=1: a load followed immediately by a user gives exactly one stall cycle, then the user forwards from MEM (src_sel=2).
- Latency with LOAD_LAT=L: a back-to-back user stalls L cycles, then forwards from stage index L (if L < NUM_FWD).
- Non-load producers never stall; they forward from EX immediately.
- A load to r0, or with id_rf_le=0, never touches the scoreboard.
- Reset in the middle of a stall clears the scoreboard. The next cycle after reset deasserts does not stall unless a new load issues.

Decomposition:
- Package hazard_pkg holds:
  - SEL_RF=0, SEL_EX=1, SEL_MEM=2, SEL_WB=3 constants.
  - A helper function for SEL_W.
  - Default values for REG_ADDR_W and LOAD_LAT.
- One natural sub-module: fwd_select. It is the combinational priority match of one source against NUM_FWD stages and is instantiated NUM_SRC times via generate.
- The scoreboard counters and control outputs remain in the top level.

Test Plan:
- ADD r3 in EX (fwd_rd[0]=3, fwd_rf_le[0]=1) while the ID instruction reads r3 in slot 0 -> src_sel slot0=1, nop=0, id_le=1.
- r3 matches both EX and WB -> src_sel=1. r3 matches only WB -> src_sel=3. A read of r0 with r0 shown as an EX destination -> src_sel=0.
- LOAD_LAT=1: load r5 issues, user of r5 follows in ID -> one cycle of nop=1 and id_le=0, stall_cycles=1; next cycle src_sel=2, nop=0.
- LOAD_LAT=3: load r7 issues, then a dependent instruction is held in ID -> 3 stall cycles, sb_busy=1 for those 3 cycles and then 0, stall_cycles=3.
- During a pending load stall, pulse flush -> nop=1, id_le=1, no issue. Same cycle: stall_clr=1 -> stall_cycles=0 next cycle.
- Assert rst_n=0 mid-stall (cnt[5]=2) -> next cycle sb_busy=0, no stall. STALL_CNT_W=4 with 20 stall cycles -> stall_cycles holds at 15.
